// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 256;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_if.sv
// ============================================================================
// Module      : mem_arb_if
// Description : Requester and memory-side signals of the arbiter, bundled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              p0_req_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;
    logic [DATA_W-1:0] p0_data_o;
    logic              p0_ack_o;

    logic              p1_req_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;
    logic [DATA_W-1:0] p1_data_o;
    logic              p1_ack_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    // Arbiter view
    modport master (
        input  p0_req_i, p0_write_i, p0_addr_i, p0_data_i,
        output p0_data_o, p0_ack_o,
        input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_ack_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    // Caches-plus-memory view
    modport slave (
        output p0_req_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p0_data_o, p0_ack_o,
        output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_ack_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner select; round-robin on last grant, or
//               fixed dcache priority when MEM_ARB_DCACHE_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifndef MEM_ARB_DCACHE_PRIO_EN
    input  logic last_i,
`endif
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        gnt_o   = PORT_I;
        if (req0_i && req1_i) begin
`ifdef MEM_ARB_DCACHE_PRIO_EN
            gnt_o = PORT_D;
`else
            // Tie goes to whichever port was not served last
            gnt_o = ~last_i;
`endif
        end else if (req1_i) begin
            gnt_o = PORT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between icache (port 0) and dcache
//               (port 1). Option macro: MEM_ARB_DCACHE_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mem_arb_if.master bus
);

    arb_state_e        state_q, state_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
`ifndef MEM_ARB_DCACHE_PRIO_EN
    logic              last_q, last_d;
`endif

    logic              w_pick_gnt;
    logic              w_pick_valid;

    mem_arb_pick u_pick (
`ifndef MEM_ARB_DCACHE_PRIO_EN
        .last_i  (last_q),
`endif
        .req0_i  (bus.p0_req_i),
        .req1_i  (bus.p1_req_i),
        .gnt_o   (w_pick_gnt),
        .valid_o (w_pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
`ifndef MEM_ARB_DCACHE_PRIO_EN
        last_d       = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    mem_enable_d = 1'b1;
                    if (w_pick_gnt == PORT_D) begin
                        state_d     = GNT1;
                        mem_write_d = bus.p1_write_i;
                        mem_addr_d  = bus.p1_addr_i;
                        mem_data_d  = bus.p1_data_i;
                    end else begin
                        state_d     = GNT0;
                        mem_write_d = bus.p0_write_i;
                        mem_addr_d  = bus.p0_addr_i;
                        mem_data_d  = bus.p0_data_i;
                    end
                end
            end
            GNT0, GNT1: begin
                // Address and data stay as-is after the ack; only enable/write drop
                if (bus.mem_ack_i) begin
                    state_d      = IDLE;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
`ifndef MEM_ARB_DCACHE_PRIO_EN
                    last_d       = (state_q == GNT1) ? PORT_D : PORT_I;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
`ifndef MEM_ARB_DCACHE_PRIO_EN
            last_q       <= PORT_D;
`endif
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
`ifndef MEM_ARB_DCACHE_PRIO_EN
            last_q       <= last_d;
`endif
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

    assign bus.p0_ack_o  = bus.mem_ack_i & (state_q == GNT0);
    assign bus.p1_ack_o  = bus.mem_ack_i & (state_q == GNT1);
    assign bus.p0_data_o = bus.mem_data_i;
    assign bus.p1_data_o = bus.mem_data_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [255:0] c_pat_a5 = {32{8'hA5}};
    localparam logic [255:0] c_pat_12 = {8{32'h1234_5678}};

    mem_arb_if bus ();

    mem_arbiter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_inputs();
        bus.p0_req_i   = 1'b0;
        bus.p0_write_i = 1'b0;
        bus.p0_addr_i  = '0;
        bus.p0_data_i  = '0;
        bus.p1_req_i   = 1'b0;
        bus.p1_write_i = 1'b0;
        bus.p1_addr_i  = '0;
        bus.p1_data_i  = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        step();
        step();
        rst_i = 1'b0;
    endtask

    // Pulse mem_ack for one cycle; check which port sees it, then leave the cycle
    task automatic ack_cycle(input string tag, input logic exp0, input logic exp1);
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = c_pat_a5;
        #1;
        check({tag, "_p0_ack"}, bus.p0_ack_o, exp0);
        check({tag, "_p1_ack"}, bus.p1_ack_o, exp1);
        step();
        bus.mem_ack_i = 1'b0;
    endtask

    initial begin
        // Reset state
        clear_inputs();
        step();
        check("rst_enable", bus.mem_enable_o, 1'b0);
        check("rst_write",  bus.mem_write_o,  1'b0);
        check("rst_addr",   bus.mem_addr_o,   '0);
        check("rst_data",   bus.mem_data_o,   '0);
        check("rst_p0_ack", bus.p0_ack_o,     1'b0);
        check("rst_p1_ack", bus.p1_ack_o,     1'b0);
        do_reset();

        // Single read on port 1, ack ten cycles after the grant
        bus.p1_req_i  = 1'b1;
        bus.p1_addr_i = 32'h0000_0400;
        step();
        check("rd_enable", bus.mem_enable_o, 1'b1);
        check("rd_addr",   bus.mem_addr_o,   32'h400);
        check("rd_write",  bus.mem_write_o,  1'b0);
        repeat (9) step();
        check("rd_hold_enable", bus.mem_enable_o, 1'b1);
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = c_pat_a5;
        #1;
        check("rd_p1_ack",  bus.p1_ack_o,  1'b1);
        check("rd_p0_ack",  bus.p0_ack_o,  1'b0);
        check("rd_p1_data", bus.p1_data_o, c_pat_a5);
        step();
        bus.mem_ack_i = 1'b0;
        bus.p1_req_i  = 1'b0;
        check("rd_done_enable", bus.mem_enable_o, 1'b0);

`ifndef MEM_ARB_DCACHE_PRIO_EN
        // Round-robin: tie after reset goes to p0, then p1, then p0 again
        do_reset();
        bus.p0_req_i  = 1'b1;
        bus.p0_addr_i = 32'h100;
        bus.p1_req_i  = 1'b1;
        bus.p1_addr_i = 32'h180;
        step();
        check("rr1_addr", bus.mem_addr_o, 32'h100);
        ack_cycle("rr1", 1'b1, 1'b0);
        bus.p0_req_i = 1'b0;
        check("rr_gap_enable", bus.mem_enable_o, 1'b0);
        step();
        check("rr2_enable", bus.mem_enable_o, 1'b1);
        check("rr2_addr",   bus.mem_addr_o,   32'h180);
        ack_cycle("rr2", 1'b0, 1'b1);
        bus.p0_req_i = 1'b1;
        step();
        check("rr3_addr", bus.mem_addr_o, 32'h100);
        ack_cycle("rr3", 1'b1, 1'b0);
        bus.p0_req_i = 1'b0;
        bus.p1_req_i = 1'b0;
`else
        // Fixed priority: dcache wins every tie
        do_reset();
        bus.p0_req_i  = 1'b1;
        bus.p0_addr_i = 32'h100;
        bus.p1_req_i  = 1'b1;
        bus.p1_addr_i = 32'h180;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fp_addr", bus.mem_addr_o, 32'h180);
            ack_cycle("fp", 1'b0, 1'b1);
            check("fp_gap_enable", bus.mem_enable_o, 1'b0);
        end
        bus.p0_req_i = 1'b0;
        bus.p1_req_i = 1'b0;
        step();
`endif

        // Write on port 0; request dropped mid-grant must still complete
        do_reset();
        bus.p0_req_i   = 1'b1;
        bus.p0_write_i = 1'b1;
        bus.p0_addr_i  = 32'h200;
        bus.p0_data_i  = c_pat_12;
        step();
        for (int i = 0; i < 3; i++) begin
            check("wr_write",  bus.mem_write_o, 1'b1);
            check("wr_data",   bus.mem_data_o,  c_pat_12);
            check("wr_addr",   bus.mem_addr_o,  32'h200);
            check("wr_p1_ack", bus.p1_ack_o,    1'b0);
            if (i == 1) begin
                bus.p0_req_i  = 1'b0;
                bus.p0_data_i = '0;
            end
            step();
        end
        ack_cycle("wr", 1'b1, 1'b0);
        check("wr_done_write",  bus.mem_write_o,  1'b0);
        check("wr_done_enable", bus.mem_enable_o, 1'b0);

        // Stray ack in IDLE
        ack_cycle("stray", 1'b0, 1'b0);
        check("stray_enable", bus.mem_enable_o, 1'b0);
        bus.p1_req_i  = 1'b1;
        bus.p1_addr_i = 32'h480;
        step();
        check("stray_grant_addr", bus.mem_addr_o, 32'h480);
        ack_cycle("stray_grant", 1'b0, 1'b1);
        bus.p1_req_i = 1'b0;

        // Reset during GNT1
        step();
        bus.p1_req_i   = 1'b1;
        bus.p1_write_i = 1'b1;
        bus.p1_addr_i  = 32'h400;
        bus.p1_data_i  = c_pat_a5;
        step();
        check("mid_enable_pre", bus.mem_enable_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("mid_enable", bus.mem_enable_o, 1'b0);
        check("mid_write",  bus.mem_write_o,  1'b0);
        check("mid_addr",   bus.mem_addr_o,   '0);
        check("mid_data",   bus.mem_data_o,   '0);
        clear_inputs();
        step();
        rst_i = 1'b0;
        ack_cycle("mid_late", 1'b0, 1'b0);
        bus.p0_req_i  = 1'b1;
        bus.p0_addr_i = 32'h300;
        step();
        check("mid_new_enable", bus.mem_enable_o, 1'b1);
        check("mid_new_addr",   bus.mem_addr_o,   32'h300);
        ack_cycle("mid_new", 1'b1, 1'b0);
        bus.p0_req_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 256-bit off-chip data memory port between the instruction-side cache (port 0) and `dcache_top` (port 1). It sits between the caches and the `mem_*` pins of `CPU`. It grants one requester at a time, registers that requester's command onto the memory interface, and holds the grant until `mem_ack_i`. It then routes the ack and the read data back to the granted requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 256, cache-line width

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  asynchronous reset, active-high
- `p0_req_i`  in  1  port 0 (icache) request
- `p0_write_i`  in  1  port 0 write (1) / read (0)
- `p0_addr_i`  in  ADDR_W  port 0 line address
- `p0_data_i`  in  DATA_W  port 0 write data
- `p0_data_o`  out  DATA_W  port 0 read data
- `p0_ack_o`  out  1  port 0 completion
- `p1_req_i`, `p1_write_i`, `p1_addr_i`, `p1_data_i`, `p1_data_o`, `p1_ack_o`: same as port 0, for the dcache
- `mem_enable_o`  out  1  memory request, held until ack
- `mem_write_o`  out  1  memory write
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_data_o`  out  DATA_W  memory write data
- `mem_data_i`  in  DATA_W  memory read data
- `mem_ack_i`  in  1  memory completion, 1-cycle pulse

## Operation
- **FSM states:** IDLE, GNT0, GNT1.
- **IDLE:**
  - Samples `p0_req_i` and `p1_req_i` at each edge.
  - If any request is present, picks a winner and moves to GNT0 or GNT1.
  - On the same edge it registers `mem_enable_o=1` and copies the winner's write, addr and data onto the `mem_*` outputs.
- **GNTx:**
  - `mem_*` outputs are held stable.
  - Requester inputs are ignored. The requester must hold them anyway until its ack.
  - On `mem_ack_i`, the next edge moves to IDLE, clears `mem_enable_o` and `mem_write_o`, and updates the priority pointer.
- **Ack routing:**
  - `pX_ack_o = mem_ack_i & (state==GNTX)`, combinational, in the ack cycle.
  - A requester drops or changes its request at the edge that ends its ack cycle.
- **Read data:** `p0_data_o` and `p1_data_o` both equal `mem_data_i`, combinational. Data is valid only while the port's ack is high.
- **Arbitration:**
  - Round-robin: `last_q` records the last granted port.
  - On a simultaneous request, the port not equal to `last_q` wins.
  - A single request always wins.
- **Boundary cases:**
  - `mem_ack_i` in IDLE is ignored; no ack is produced.
  - A request dropped during GNTx does not abort the transaction; the grant completes on `mem_ack_i` and the ack pulse is still driven.
  - Back-to-back: the other port's pending request is granted at the first edge after the return to IDLE.
  - Reset mid-transaction abandons the access, and any later ack is ignored.
- **Reset values:**
  - state=IDLE, `last_q`=1 (port 0 wins the first tie).
  - `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - `pX_ack_o`=0.

## Timing
- Request to `mem_enable_o`: 1 cycle (registered).
- `mem_ack_i` to `pX_ack_o`: 0 cycles (same cycle).
- `mem_ack_i` to `mem_enable_o` low: 1 cycle.
- Minimum gap between two memory transactions: 1 IDLE cycle. `mem_enable_o` is low for at least one cycle between grants.
- No combinational path from `pX_req_i` to any `mem_*` output.

## Configuration
- `MEM_ARB_DCACHE_PRIO_EN` defined: fixed priority.
  - Port 1 (dcache) always wins a simultaneous request.
  - `last_q` is not implemented.
  - The reset tie-break is port 1.
- Undefined: round-robin as described in Operation.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, GNT0, GNT1)
  - port index constants `PORT_I=0`, `PORT_D=1`
  - default `ADDR_W` and `DATA_W`
- One sub-module, `mem_arb_pick`: a combinational winner selector taking the two requests and `last_q`, producing a grant index and a valid bit. It also carries the `MEM_ARB_DCACHE_PRIO_EN` variant.

## Test plan
- **Single read:** p1 read request, addr 0x0000_0400, held → `mem_enable_o`=1 and `mem_addr_o`=0x400 one cycle later. Memory returns data 0xA5…A5 with ack 10 cycles later → `p1_ack_o` and data 0xA5…A5 in that cycle, `mem_enable_o`=0 the next cycle.
- **Simultaneous requests after reset (round-robin):** p0 granted first. After its ack, p1 is granted after exactly one idle cycle. A second tie then goes to p0.
- **Fixed priority:** with `MEM_ARB_DCACHE_PRIO_EN`, three consecutive ties → p1 granted all three times.
- **Write:** p0 write, addr 0x200, data 0x1234… → `mem_write_o`=1 with that data for the whole grant. `p1_ack_o` stays 0 throughout.
- **Stray ack:** `mem_ack_i` pulsed while in IDLE → no `pX_ack_o`, state unchanged.
- **Reset mid-grant:** `rst_i` asserted during GNT1 → all outputs 0 immediately. A later `mem_ack_i` produces no ack, and a new p0 request is granted normally.
